// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM command port between the CPU PRG-read path,
// the PPU CHR-read path, the SDIO loader write path and a periodic refresh
// scheduler. Exactly one SDRAM operation is outstanding at a time. Grants use
// fixed priority: refresh > ppu > cpu > loader.
module sdram_arbiter #(
    parameter int ADDR_BITS        = 24,
    parameter int REFRESH_INTERVAL = 780
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_state,
    input  logic [ADDR_BITS-1:0] prg_offset,
    input  logic [ADDR_BITS-1:0] chr_offset,
    input  logic                 cpu_req,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    output logic                 cpu_ack,
    output logic [15:0]          cpu_rdata,
    input  logic                 ppu_req,
    input  logic [ADDR_BITS-1:0] ppu_addr,
    output logic                 ppu_ack,
    output logic [15:0]          ppu_rdata,
    input  logic                 ld_req,
    input  logic [ADDR_BITS-1:0] ld_addr,
    input  logic [15:0]          ld_wdata,
    output logic                 ld_ack,
    output logic                 mem_cmd_valid,
    input  logic                 mem_cmd_ready,
    output logic [1:0]           mem_cmd_op,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [15:0]          mem_wdata,
    input  logic                 mem_done,
    input  logic [15:0]          mem_rdata,
    output logic                 refresh_overrun
);

    localparam int                CNT_W      = $clog2(REFRESH_INTERVAL);
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_REFRESH = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        GNT_REF = 2'b00,
        GNT_PPU = 2'b01,
        GNT_CPU = 2'b10,
        GNT_LD  = 2'b11
    } gnt_t;

    state_t                 state_r;
    gnt_t                   gnt_r;
    logic [CNT_W-1:0]       ref_cnt_r;
    logic                   ref_pend_r;
    logic                   cpu_pend_r;
    logic                   ppu_pend_r;
    logic                   ld_pend_r;
    logic [ADDR_BITS-1:0]   cpu_addr_r;
    logic [ADDR_BITS-1:0]   ppu_addr_r;
    logic [ADDR_BITS-1:0]   ld_addr_r;
    logic [15:0]            ld_wdata_r;

    logic                   ref_fire_s;
    logic                   done_s;
    logic                   ref_clr_s;
    logic                   cpu_clr_s;
    logic                   ppu_clr_s;
    logic                   ld_clr_s;
    logic                   cpu_take_s;
    logic                   ppu_take_s;
    logic                   ld_take_s;

    assign ref_fire_s = (ref_cnt_r == {CNT_W{1'b0}});
    assign done_s     = (state_r == ST_WAIT) && mem_done;
    assign ref_clr_s  = done_s && (gnt_r == GNT_REF);
    assign ppu_clr_s  = done_s && (gnt_r == GNT_PPU);
    assign cpu_clr_s  = done_s && (gnt_r == GNT_CPU);
    assign ld_clr_s   = done_s && (gnt_r == GNT_LD);

    // A request completing this cycle frees its slot, so a new request of the
    // same requester in that cycle is accepted (set wins over clear).
    assign cpu_take_s = cpu_req && !load_state && (!cpu_pend_r || cpu_clr_s);
    assign ppu_take_s = ppu_req && !load_state && (!ppu_pend_r || ppu_clr_s);
    assign ld_take_s  = ld_req && (!ld_pend_r || ld_clr_s);

    // Refresh interval timer: counts down and reloads when it reaches zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_r <= CNT_RELOAD;
        end else if (ref_fire_s) begin
            ref_cnt_r <= CNT_RELOAD;
        end else begin
            ref_cnt_r <= ref_cnt_r - CNT_ONE;
        end
    end

    // Pending flags, offset address capture and sticky refresh overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_pend_r      <= 1'b0;
            cpu_pend_r      <= 1'b0;
            ppu_pend_r      <= 1'b0;
            ld_pend_r       <= 1'b0;
            cpu_addr_r      <= {ADDR_BITS{1'b0}};
            ppu_addr_r      <= {ADDR_BITS{1'b0}};
            ld_addr_r       <= {ADDR_BITS{1'b0}};
            ld_wdata_r      <= 16'h0000;
            refresh_overrun <= 1'b0;
        end else begin
            if (ref_fire_s && ref_pend_r) begin
                refresh_overrun <= 1'b1;
            end
            if (ref_fire_s) begin
                ref_pend_r <= 1'b1;
            end else if (ref_clr_s) begin
                ref_pend_r <= 1'b0;
            end
            if (cpu_take_s) begin
                cpu_pend_r <= 1'b1;
                cpu_addr_r <= cpu_addr + prg_offset;
            end else if (cpu_clr_s) begin
                cpu_pend_r <= 1'b0;
            end
            if (ppu_take_s) begin
                ppu_pend_r <= 1'b1;
                ppu_addr_r <= ppu_addr + chr_offset;
            end else if (ppu_clr_s) begin
                ppu_pend_r <= 1'b0;
            end
            if (ld_take_s) begin
                ld_pend_r  <= 1'b1;
                ld_addr_r  <= ld_addr;
                ld_wdata_r <= ld_wdata;
            end else if (ld_clr_s) begin
                ld_pend_r <= 1'b0;
            end
        end
    end

    // Command FSM: grant in IDLE, hold command until accepted, await completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            gnt_r         <= GNT_REF;
            mem_cmd_valid <= 1'b0;
            mem_cmd_op    <= 2'b00;
            mem_addr      <= {ADDR_BITS{1'b0}};
            mem_wdata     <= 16'h0000;
            cpu_ack       <= 1'b0;
            ppu_ack       <= 1'b0;
            ld_ack        <= 1'b0;
            cpu_rdata     <= 16'h0000;
            ppu_rdata     <= 16'h0000;
        end else begin
            cpu_ack <= 1'b0;
            ppu_ack <= 1'b0;
            ld_ack  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ref_pend_r) begin
                        gnt_r         <= GNT_REF;
                        mem_cmd_op    <= OP_REFRESH;
                        mem_addr      <= {ADDR_BITS{1'b0}};
                        mem_wdata     <= 16'h0000;
                        mem_cmd_valid <= 1'b1;
                        state_r       <= ST_ISSUE;
                    end else if (ppu_pend_r) begin
                        gnt_r         <= GNT_PPU;
                        mem_cmd_op    <= OP_READ;
                        mem_addr      <= ppu_addr_r;
                        mem_wdata     <= 16'h0000;
                        mem_cmd_valid <= 1'b1;
                        state_r       <= ST_ISSUE;
                    end else if (cpu_pend_r) begin
                        gnt_r         <= GNT_CPU;
                        mem_cmd_op    <= OP_READ;
                        mem_addr      <= cpu_addr_r;
                        mem_wdata     <= 16'h0000;
                        mem_cmd_valid <= 1'b1;
                        state_r       <= ST_ISSUE;
                    end else if (ld_pend_r) begin
                        gnt_r         <= GNT_LD;
                        mem_cmd_op    <= OP_WRITE;
                        mem_addr      <= ld_addr_r;
                        mem_wdata     <= ld_wdata_r;
                        mem_cmd_valid <= 1'b1;
                        state_r       <= ST_ISSUE;
                    end else begin
                        mem_cmd_valid <= 1'b0;
                        state_r       <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_cmd_ready) begin
                        mem_cmd_valid <= 1'b0;
                        state_r       <= ST_WAIT;
                    end else begin
                        mem_cmd_valid <= 1'b1;
                        state_r       <= ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (mem_done) begin
                        case (gnt_r)
                            GNT_PPU: begin
                                ppu_rdata <= mem_rdata;
                                ppu_ack   <= 1'b1;
                            end
                            GNT_CPU: begin
                                cpu_rdata <= mem_rdata;
                                cpu_ack   <= 1'b1;
                            end
                            GNT_LD: begin
                                ld_ack <= 1'b1;
                            end
                            default: begin
                                ld_ack <= 1'b0;
                            end
                        endcase
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    mem_cmd_valid <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: randomized and directed stimulus against a transaction
// level reference model; the bench also plays the SDRAM controller.
module tb_sdram_arbiter;

    localparam int AB = 24;
    localparam int RI = 780;
    localparam int R_REF = 0;
    localparam int R_PPU = 1;
    localparam int R_CPU = 2;
    localparam int R_LD  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_state = 1'b0;
    logic [AB-1:0] prg_offset = '0;
    logic [AB-1:0] chr_offset = '0;
    logic          cpu_req = 1'b0;
    logic [AB-1:0] cpu_addr = '0;
    logic          cpu_ack;
    logic [15:0]   cpu_rdata;
    logic          ppu_req = 1'b0;
    logic [AB-1:0] ppu_addr = '0;
    logic          ppu_ack;
    logic [15:0]   ppu_rdata;
    logic          ld_req = 1'b0;
    logic [AB-1:0] ld_addr = '0;
    logic [15:0]   ld_wdata = '0;
    logic          ld_ack;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready = 1'b0;
    logic [1:0]    mem_cmd_op;
    logic [AB-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_done = 1'b0;
    logic [15:0]   mem_rdata = '0;
    logic          refresh_overrun;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_BITS(AB), .REFRESH_INTERVAL(RI)) dut (
        .clk(clk), .rst_n(rst_n), .load_state(load_state),
        .prg_offset(prg_offset), .chr_offset(chr_offset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_rdata(ppu_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_op(mem_cmd_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .refresh_overrun(refresh_overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: pending set per requester, one outstanding job.
    int            m_cnt;
    bit            m_pend [4];
    logic [AB-1:0] m_addr [4];
    logic [15:0]   m_wd;
    bit            m_ovr;
    int            m_stage;   // 0 free, 1 command offered, 2 awaiting completion
    int            m_gnt;
    bit            e_valid;
    logic [1:0]    e_op;
    logic [AB-1:0] e_addr;
    logic [15:0]   e_wdata;
    bit            e_ack [4];
    logic [15:0]   e_crd;
    logic [15:0]   e_prd;
    int            ctl_delay;
    bit            stall;
    bit            force_rd;
    logic [15:0]   force_val;

    task automatic model_reset();
        m_cnt = RI - 1;
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 1'b0;
            m_addr[i] = '0;
            e_ack[i]  = 1'b0;
        end
        m_wd = '0; m_ovr = 1'b0; m_stage = 0; m_gnt = 0;
        e_valid = 1'b0; e_op = 2'b00; e_addr = '0; e_wdata = '0;
        e_crd = '0; e_prd = '0; ctl_delay = 0;
    endtask

    task automatic check_outputs();
        chk("valid", mem_cmd_valid, e_valid);
        if (e_valid) begin
            chk("op", mem_cmd_op, e_op);
            chk("addr", mem_addr, e_addr);
            chk("wdata", mem_wdata, e_wdata);
        end
        chk("cpu_ack", cpu_ack, e_ack[R_CPU]);
        chk("ppu_ack", ppu_ack, e_ack[R_PPU]);
        chk("ld_ack", ld_ack, e_ack[R_LD]);
        chk("cpu_rdata", cpu_rdata, e_crd);
        chk("ppu_rdata", ppu_rdata, e_prd);
        chk("overrun", refresh_overrun, m_ovr);
    endtask

    // One clock: controller response, model prediction, edge, then compare.
    task automatic tick();
        bit fire;
        bit done_now;
        bit found;
        int clr;
        mem_done = 1'b0;
        mem_cmd_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (m_stage == 2) begin
            if (ctl_delay == 0) begin
                mem_done  = 1'b1;
                mem_rdata = force_rd ? force_val : 16'($urandom);
            end else begin
                ctl_delay--;
            end
        end
        fire     = (m_cnt == 0);
        done_now = (m_stage == 2) && mem_done;
        clr      = done_now ? m_gnt : -1;
        for (int i = 0; i < 4; i++) e_ack[i] = done_now && (m_gnt == i) && (i != R_REF);
        if (done_now && m_gnt == R_CPU) e_crd = mem_rdata;
        if (done_now && m_gnt == R_PPU) e_prd = mem_rdata;
        if (m_stage == 0) begin
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!found && m_pend[i]) begin
                    found   = 1'b1;
                    m_gnt   = i;
                    e_valid = 1'b1;
                    m_stage = 1;
                    e_op    = (i == R_REF) ? 2'b10 : (i == R_LD) ? 2'b01 : 2'b00;
                    e_addr  = (i == R_REF) ? '0 : m_addr[i];
                    e_wdata = (i == R_LD) ? m_wd : 16'h0000;
                end
            end
        end else if (m_stage == 1) begin
            if (mem_cmd_ready) begin
                e_valid   = 1'b0;
                m_stage   = 2;
                ctl_delay = $urandom_range(0, 3);
            end
        end else if (done_now) begin
            m_stage = 0;
        end
        if (fire && m_pend[R_REF]) m_ovr = 1'b1;
        if (fire) m_pend[R_REF] = 1'b1;
        else if (clr == R_REF) m_pend[R_REF] = 1'b0;
        if (cpu_req && !load_state && (!m_pend[R_CPU] || clr == R_CPU)) begin
            m_pend[R_CPU] = 1'b1;
            m_addr[R_CPU] = cpu_addr + prg_offset;
        end else if (clr == R_CPU) m_pend[R_CPU] = 1'b0;
        if (ppu_req && !load_state && (!m_pend[R_PPU] || clr == R_PPU)) begin
            m_pend[R_PPU] = 1'b1;
            m_addr[R_PPU] = ppu_addr + chr_offset;
        end else if (clr == R_PPU) m_pend[R_PPU] = 1'b0;
        if (ld_req && (!m_pend[R_LD] || clr == R_LD)) begin
            m_pend[R_LD] = 1'b1;
            m_addr[R_LD] = ld_addr;
            m_wd         = ld_wdata;
        end else if (clr == R_LD) m_pend[R_LD] = 1'b0;
        m_cnt = fire ? RI - 1 : m_cnt - 1;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        ppu_req = 1'b0;
        ld_req  = 1'b0;
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, mem_cmd_valid, 32'd0);
        chk({tag, "_op"}, mem_cmd_op, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_acks"}, {cpu_ack, ppu_ack, ld_ack}, 32'd0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
        chk({tag, "_ppu_rdata"}, ppu_rdata, 32'd0);
        chk({tag, "_overrun"}, refresh_overrun, 32'd0);
    endtask

    int            n;
    int            first_ack;
    int            second_ack;
    int            cnt_a;
    int            cnt_b;
    logic [AB-1:0] seen_addr;
    logic [15:0]   seen_wd;
    logic [1:0]    snap_op;
    logic [AB-1:0] snap_addr;
    logic [15:0]   snap_wd;

    initial begin
        stall = 1'b0; force_rd = 1'b0; force_val = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // 1: idle until the first refresh command
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_cmd_valid && n < 900);
        chk("t1_ref_cycle", n, RI + 1);
        chk("t1_ref_op", mem_cmd_op, 32'd2);
        chk("t1_ref_addr", mem_addr, 32'd0);

        // 2: PRG read with offset
        prg_offset = 24'h008000;
        cpu_addr = 24'h000010;
        cpu_req = 1'b1;
        force_rd = 1'b1; force_val = 16'hBEEF;
        seen_addr = '0; n = 0;
        do begin
            tick();
            if (mem_cmd_valid && mem_cmd_op == 2'b00) seen_addr = mem_addr;
            n++;
        end while (!cpu_ack && n < 60);
        chk("t2_addr", seen_addr, 32'h008010);
        chk("t2_ack", cpu_ack, 32'd1);
        chk("t2_rdata", cpu_rdata, 32'h0000BEEF);
        force_rd = 1'b0;

        // 3: simultaneous CPU and PPU requests, PPU served first
        cpu_addr = AB'($urandom); ppu_addr = AB'($urandom);
        cpu_req = 1'b1; ppu_req = 1'b1;
        first_ack = 0; second_ack = 0; n = 0;
        do begin
            tick();
            if (ppu_ack || cpu_ack) begin
                if (first_ack == 0) first_ack = ppu_ack ? 1 : 2;
                else second_ack = ppu_ack ? 1 : 2;
            end
            n++;
        end while (second_ack == 0 && n < 80);
        chk("t3_first", first_ack, 32'd1);
        chk("t3_second", second_ack, 32'd2);

        // 4: loading blocks CPU, loader write goes through
        load_state = 1'b1;
        cpu_addr = 24'h000200; cpu_req = 1'b1;
        ld_addr = 24'h001234; ld_wdata = 16'hA5A5; ld_req = 1'b1;
        cnt_a = 0; cnt_b = 0; seen_addr = '0; seen_wd = '0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (mem_cmd_valid && mem_cmd_op == 2'b01) begin
                seen_addr = mem_addr;
                seen_wd = mem_wdata;
            end
            if (cpu_ack) cnt_a++;
            if (ld_ack) cnt_b++;
        end
        chk("t4_ld_acks", cnt_b, 32'd1);
        chk("t4_cpu_acks", cnt_a, 32'd0);
        chk("t4_waddr", seen_addr, 32'h001234);
        chk("t4_wdata", seen_wd, 32'h0000A5A5);
        load_state = 1'b0;

        // Random traffic
        for (int i = 0; i < 5000; i++) begin
            cpu_req = ($urandom_range(0, 5) == 0);
            ppu_req = ($urandom_range(0, 5) == 0);
            ld_req  = ($urandom_range(0, 7) == 0);
            cpu_addr = AB'($urandom); ppu_addr = AB'($urandom);
            ld_addr = AB'($urandom); ld_wdata = 16'($urandom);
            if ($urandom_range(0, 199) == 0) load_state = ~load_state;
            if ($urandom_range(0, 299) == 0) prg_offset = AB'($urandom);
            if ($urandom_range(0, 299) == 0) chr_offset = AB'($urandom);
            tick();
        end
        load_state = 1'b0;

        // 5: stalled controller, command held, refresh overruns
        stall = 1'b1;
        ld_addr = 24'h00ABCD; ld_wdata = 16'h1357; ld_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_cmd_valid && n < 900);
        chk("t5_valid", mem_cmd_valid, 32'd1);
        snap_op = mem_cmd_op; snap_addr = mem_addr; snap_wd = mem_wdata;
        for (int i = 0; i < 1700; i++) begin
            tick();
            if (i < 10) begin
                chk("t5_hold_valid", mem_cmd_valid, 32'd1);
                chk("t5_hold_op", mem_cmd_op, snap_op);
                chk("t5_hold_addr", mem_addr, snap_addr);
                chk("t5_hold_wd", mem_wdata, snap_wd);
            end
        end
        chk("t5_overrun", refresh_overrun, 32'd1);
        stall = 1'b0;
        repeat (100) tick();

        // 6: reset while awaiting completion
        cpu_addr = AB'($urandom); cpu_req = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (m_stage != 2 && n < 100);
        chk("t6_reach_wait", m_stage, 32'd2);
        ctl_delay = 5;
        tick();
        #2;
        rst_n = 1'b0;
        mem_done = 1'b0;
        #1;
        check_all_zero("t6_async");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (cpu_ack || ppu_ack || ld_ack) cnt_a++;
        end
        chk("t6_no_stale_ack", cnt_a, 32'd0);
        for (int i = 0; i < 300; i++) begin
            cpu_req = ($urandom_range(0, 4) == 0);
            ppu_req = ($urandom_range(0, 4) == 0);
            ld_req  = ($urandom_range(0, 4) == 0);
            cpu_addr = AB'($urandom); ppu_addr = AB'($urandom);
            ld_addr = AB'($urandom); ld_wdata = 16'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
